// File: rtl/lieat_ifu_ibuf_pkg.sv
`default_nettype none
// ============================================================================
// Module  : lieat_ifu_ibuf_pkg
// Purpose : Shared widths for the IFU instruction buffer and a helper that
//           sizes one buffered entry ({pc, inst, prdt_taken}).
// Ports   : none (package)
// Rev     : 1.0  initial release
// ============================================================================
package lieat_ifu_ibuf_pkg;

  localparam int LIEAT_XLEN = 64;
  localparam int IBUF_DEPTH = 4;

  // One entry holds pc, the instruction word and the predicted-taken bit.
  function automatic int ibuf_entry_w(input int xlen);
    return 2 * xlen + 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/lieat_general_dfflr.sv
`default_nettype none
// ============================================================================
// Module  : lieat_general_dfflr
// Purpose : Generic load-enabled flop bank, asynchronous active-high reset
//           to zero.
// Ports   : clock   - system clock
//           reset   - asynchronous reset, active high
//           lden_i  - load enable
//           dnxt_i  - next value, captured when lden_i is high
//           qout_o  - registered value
// Rev     : 1.0  initial release
// ============================================================================
module lieat_general_dfflr #(
  parameter int DW = 32
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          lden_i,
  input  logic [DW-1:0] dnxt_i,
  output logic [DW-1:0] qout_o
);

  logic [DW-1:0] qout_q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      qout_q <= '0;
    end else if (lden_i) begin
      qout_q <= dnxt_i;
    end
  end

  assign qout_o = qout_q;

endmodule
`default_nettype wire

// File: rtl/lieat_ifu_ibuf.sv
`default_nettype none
// ============================================================================
// Module  : lieat_ifu_ibuf
// Purpose : Instruction buffer between IFU fetch output and the ID stage.
//           Circular FIFO of {pc, inst, prdt_taken} with valid/ready on both
//           sides, single-cycle flush on redirect, empty/occupancy reporting.
// Ports   : clock, reset       - clock, asynchronous active-high reset
//           in_valid/in_ready  - IFU handshake
//           in_pc/in_inst/in_prdt_taken - fetched entry
//           out_valid/out_ready - ID handshake
//           out_pc/out_inst/out_prdt_taken - head entry
//           flush              - discard all entries at the next edge
//           ibuf_empty         - no valid entries
//           ibuf_count         - occupancy, 0..DEPTH
// Rev     : 1.0  initial release
// ============================================================================
module lieat_ifu_ibuf
  import lieat_ifu_ibuf_pkg::*;
#(
  parameter int XLEN  = LIEAT_XLEN,
  parameter int DEPTH = IBUF_DEPTH,
  parameter int PTR_W = $clog2(DEPTH)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [XLEN-1:0]  in_pc,
  input  logic [XLEN-1:0]  in_inst,
  input  logic             in_prdt_taken,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_pc,
  output logic [XLEN-1:0]  out_inst,
  output logic             out_prdt_taken,
  input  logic             flush,
  output logic             ibuf_empty,
  output logic [PTR_W:0]   ibuf_count
);

  localparam int ENTRY_W = ibuf_entry_w(XLEN);

  // Pointers carry one extra wrap bit above the index so full and empty
  // are distinguishable without a separate counter.
  logic [PTR_W:0]       wr_ptr_q, wr_ptr_d;
  logic [PTR_W:0]       rd_ptr_q, rd_ptr_d;
  logic                 rd_ptr_en;
  logic                 empty, full;
  logic                 push, pop;
  logic [ENTRY_W-1:0]   entry_d;
  logic [ENTRY_W-1:0]   entry_q [DEPTH];
  logic [ENTRY_W-1:0]   head;

  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]) &&
                 (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]);

  // Flush masks both handshakes, so it wins over push and pop. in_ready
  // deliberately ignores out_ready: a full buffer refuses a push even when
  // the head is popped in the same cycle.
  assign in_ready  = !full  && !flush;
  assign out_valid = !empty && !flush;
  assign push      = in_valid  && in_ready;
  assign pop       = out_valid && out_ready;

  assign wr_ptr_d  = wr_ptr_q + (PTR_W+1)'(1);
  assign rd_ptr_d  = flush ? wr_ptr_q : (rd_ptr_q + (PTR_W+1)'(1));
  assign rd_ptr_en = pop || flush;

  lieat_general_dfflr #(.DW(PTR_W+1)) u_wr_ptr (
    .clock  (clock),
    .reset  (reset),
    .lden_i (push),
    .dnxt_i (wr_ptr_d),
    .qout_o (wr_ptr_q)
  );

  lieat_general_dfflr #(.DW(PTR_W+1)) u_rd_ptr (
    .clock  (clock),
    .reset  (reset),
    .lden_i (rd_ptr_en),
    .dnxt_i (rd_ptr_d),
    .qout_o (rd_ptr_q)
  );

  assign entry_d = {in_pc, in_inst, in_prdt_taken};

  // Storage is only written on an accepted push at the write index; a flush
  // leaves stale contents behind, which is harmless since out_valid is low.
  for (genvar i = 0; i < DEPTH; i++) begin : g_entry
    logic entry_en;
    assign entry_en = push && (wr_ptr_q[PTR_W-1:0] == PTR_W'(i));

    lieat_general_dfflr #(.DW(ENTRY_W)) u_entry (
      .clock  (clock),
      .reset  (reset),
      .lden_i (entry_en),
      .dnxt_i (entry_d),
      .qout_o (entry_q[i])
    );
  end

  assign head           = entry_q[rd_ptr_q[PTR_W-1:0]];
  assign out_pc         = head[ENTRY_W-1 -: XLEN];
  assign out_inst       = head[XLEN:1];
  assign out_prdt_taken = head[0];

  assign ibuf_empty = empty;
  assign ibuf_count = wr_ptr_q - rd_ptr_q;

endmodule
`default_nettype wire

// File: tb/tb_lieat_ifu_ibuf.sv
`default_nettype none
// ============================================================================
// Module  : tb_lieat_ifu_ibuf
// Purpose : Self-checking bench for lieat_ifu_ibuf. A queue-based reference
//           model predicts handshakes, occupancy and head contents; directed
//           scenarios are followed by randomized traffic with flushes and an
//           asynchronous reset.
// Rev     : 1.0  initial release
// ============================================================================
module tb_lieat_ifu_ibuf;

  localparam int XLEN  = 64;
  localparam int DEPTH = 4;
  localparam int PTR_W = 2;

  logic             clock = 1'b0;
  logic             reset = 1'b1;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [XLEN-1:0]  in_pc = '0;
  logic [XLEN-1:0]  in_inst = '0;
  logic             in_prdt_taken = 1'b0;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [XLEN-1:0]  out_pc;
  logic [XLEN-1:0]  out_inst;
  logic             out_prdt_taken;
  logic             flush = 1'b0;
  logic             ibuf_empty;
  logic [PTR_W:0]   ibuf_count;

  lieat_ifu_ibuf #(.XLEN(XLEN), .DEPTH(DEPTH)) dut (
    .clock          (clock),
    .reset          (reset),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .in_pc          (in_pc),
    .in_inst        (in_inst),
    .in_prdt_taken  (in_prdt_taken),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_pc         (out_pc),
    .out_inst       (out_inst),
    .out_prdt_taken (out_prdt_taken),
    .flush          (flush),
    .ibuf_empty     (ibuf_empty),
    .ibuf_count     (ibuf_count)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] inst;
    logic            taken;
  } ent_t;

  ent_t model_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  logic accepted = 1'b0;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    n_checks++;
    if (obs !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp_v);
    end
  endtask

  // Expected outputs follow directly from the model's queue length and head.
  task automatic check_outputs();
    int   sz;
    logic ev;
    sz = model_q.size();
    ev = (sz != 0) && !flush;
    check_eq("in_ready",   64'(in_ready),   64'((sz < DEPTH) && !flush));
    check_eq("out_valid",  64'(out_valid),  64'(ev));
    check_eq("ibuf_empty", 64'(ibuf_empty), 64'(sz == 0));
    check_eq("ibuf_count", 64'(ibuf_count), 64'(sz));
    if (ev) begin
      check_eq("out_pc",    out_pc,                model_q[0].pc);
      check_eq("out_inst",  out_inst,              model_q[0].inst);
      check_eq("out_taken", 64'(out_prdt_taken),   64'(model_q[0].taken));
    end
  endtask

  task automatic update_model();
    int   sz;
    logic do_push, do_pop;
    ent_t e;
    sz      = model_q.size();
    do_push = in_valid  && !flush && (sz < DEPTH);
    do_pop  = out_ready && !flush && (sz > 0);
    if (flush) begin
      model_q.delete();
    end else begin
      if (do_pop) void'(model_q.pop_front());
      if (do_push) begin
        e.pc = in_pc; e.inst = in_inst; e.taken = in_prdt_taken;
        model_q.push_back(e);
      end
    end
    accepted = do_push;
  endtask

  // One clock: check outputs mid-cycle, advance the model at the edge, and
  // return just after the edge so callers can drive the next inputs.
  task automatic step();
    @(negedge clock);
    check_outputs();
    @(posedge clock);
    update_model();
    #1;
  endtask

  task automatic async_reset_check(input string tag);
    #2;
    in_valid = 1'b0; out_ready = 1'b0; flush = 1'b0;
    reset = 1'b1;
    #1;
    check_eq({tag, "_out_valid"}, 64'(out_valid),  64'd0);
    check_eq({tag, "_out_pc"},    out_pc,          64'd0);
    check_eq({tag, "_out_inst"},  out_inst,        64'd0);
    check_eq({tag, "_count"},     64'(ibuf_count), 64'd0);
    check_eq({tag, "_empty"},     64'(ibuf_empty), 64'd1);
    check_eq({tag, "_in_ready"},  64'(in_ready),   64'd1);
    model_q.delete();
    @(negedge clock);
    reset = 1'b0;
    @(posedge clock);
    #1;
  endtask

  initial begin
    logic [XLEN-1:0] pc;
    int pushed;

    // ---------------- reset state ----------------
    repeat (2) @(posedge clock);
    #1;
    check_eq("rst_out_valid", 64'(out_valid),      64'd0);
    check_eq("rst_out_pc",    out_pc,              64'd0);
    check_eq("rst_out_inst",  out_inst,            64'd0);
    check_eq("rst_out_taken", 64'(out_prdt_taken), 64'd0);
    check_eq("rst_empty",     64'(ibuf_empty),     64'd1);
    check_eq("rst_count",     64'(ibuf_count),     64'd0);
    check_eq("rst_in_ready",  64'(in_ready),       64'd1);
    @(negedge clock);
    reset = 1'b0;
    @(posedge clock);
    #1;

    // ---------------- single entry ----------------
    in_valid = 1'b1; in_pc = 64'h8000_0000; in_inst = 64'h13; in_prdt_taken = 1'b0;
    out_ready = 1'b1;
    step();
    in_valid = 1'b0;
    step();
    step();
    check_eq("single_empty", 64'(ibuf_empty), 64'd1);

    // ---------------- fill ----------------
    out_ready = 1'b0;
    pc = 64'h8000_0000;
    in_valid = 1'b1;
    for (int k = 0; k < 6; k++) begin
      in_pc = pc; in_inst = {32'h0, $urandom}; in_prdt_taken = 1'($urandom);
      step();
      if (accepted) pc += 4;
    end
    check_eq("fill_count",    64'(ibuf_count), 64'd4);
    check_eq("fill_in_ready", 64'(in_ready),   64'd0);
    check_eq("fill_held_pc",  in_pc,           64'h8000_0010);
    in_valid = 1'b0; out_ready = 1'b1;
    repeat (5) step();

    // ---------------- wrap, one in / one out ----------------
    pc = 64'h8000_0100; pushed = 0;
    out_ready = 1'b1;
    for (int k = 0; k < 12; k++) begin
      in_valid = (pushed < 10);
      in_pc = pc; in_inst = {$urandom, $urandom}; in_prdt_taken = 1'($urandom);
      step();
      check_eq("wrap_cnt_le1", 64'(ibuf_count <= 1), 64'd1);
      if (accepted) begin pc += 4; pushed++; end
    end
    check_eq("wrap_pushed", 64'(pushed), 64'd10);

    // ---------------- flush ----------------
    out_ready = 1'b0; in_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      in_pc = 64'h8000_0200 + 64'(4 * k); in_inst = {$urandom, $urandom};
      step();
    end
    flush = 1'b1; in_valid = 1'b1; out_ready = 1'b1; in_pc = 64'h8000_0dead;
    step();
    flush = 1'b0; in_valid = 1'b1; out_ready = 1'b0;
    in_pc = 64'h8000_1000; in_inst = 64'h13; in_prdt_taken = 1'b1;
    step();
    in_valid = 1'b0;
    step();
    check_eq("flush_head_pc", out_pc, 64'h8000_1000);
    out_ready = 1'b1;
    step();

    // ---------------- full plus pop ----------------
    out_ready = 1'b0; in_valid = 1'b1;
    for (int k = 0; k < 4; k++) begin
      in_pc = 64'h8000_0300 + 64'(4 * k); in_inst = {$urandom, $urandom};
      step();
    end
    in_pc = 64'h8000_0310; out_ready = 1'b1;
    step();
    check_eq("fullpop_count",    64'(ibuf_count), 64'd3);
    check_eq("fullpop_in_ready", 64'(in_ready),   64'd1);
    in_valid = 1'b0;
    repeat (4) step();

    // ---------------- async reset with 2 entries held ----------------
    out_ready = 1'b0; in_valid = 1'b1;
    for (int k = 0; k < 2; k++) begin
      in_pc = 64'h8000_0400 + 64'(4 * k); in_inst = {$urandom, $urandom};
      step();
    end
    async_reset_check("arst");

    // ---------------- randomized traffic ----------------
    pc = 64'h8000_2000;
    in_pc = pc; in_inst = {$urandom, $urandom}; in_prdt_taken = 1'($urandom);
    for (int k = 0; k < 400; k++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      flush     = ($urandom_range(0, 15) == 0);
      step();
      if (accepted) begin
        pc += 4;
        in_pc = pc; in_inst = {$urandom, $urandom}; in_prdt_taken = 1'($urandom);
      end
      if (k == 200) async_reset_check("rnd_arst");
    end
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    repeat (6) step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
